// File: rtl/ifu_mem_responder.sv
// ifu_mem_responder: memory-side refill responder for ifu_cache.
// Queues deduplicated miss tags and reads four words per line from a word-wide RAM
// with a fixed read latency. Each assembled line goes back with its tag as a
// one-cycle valid pulse.
module ifu_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
  parameter int LINE_WIDTH   = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_DEPTH    = 1024,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                         Clock,
  input  logic                         Rst,
  input  logic [TAG_WIDTH-1:0]         mem_reqTagIn,
  input  logic                         mem_reqTagValidIn,
  output logic [TAG_WIDTH-1:0]         mem_rspTagOut,
  output logic [LINE_WIDTH-1:0]        mem_rspInsLineOut,
  output logic                         mem_rspInsLineValidOut,
  input  logic                         ld_wrEnIn,
  input  logic [$clog2(MEM_DEPTH)-1:0] ld_wrAddrIn,
  input  logic [WORD_WIDTH-1:0]        ld_wrDataIn,
  output logic                         busyOut,
  output logic                         overflowOut
);

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int FPW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, WAIT = 2'd2, RESP = 2'd3} stateT;

  logic [WORD_WIDTH-1:0] ram [MEM_DEPTH];
  logic [TAG_WIDTH-1:0]  fifoMem [FIFO_DEPTH];
  logic [FPW-1:0]        wrPtr, rdPtr, newestPtr;
  logic [FPW:0]          fifoCount;
  logic                  fifoEmpty, fifoFull;

  stateT                 state;
  logic [1:0]            fetchIdx;
  logic [TAG_WIDTH-1:0]  curTag;
  logic                  lineDone;
  logic [LINE_WIDTH-1:0] lineReg;
  logic                  prevRspVld;
  logic [TAG_WIDTH-1:0]  prevRspTag;

  logic [WORD_WIDTH-1:0]   rdWord_p [READ_LATENCY];
  logic [1:0]              idx_p    [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;

  logic          isDup, reqNew, popEn, pushEn, dropEn;
  logic [AW-1:0] ramAddr;

  // Line address {tag, word} wraps modulo the RAM depth by plain truncation.
  assign ramAddr   = AW'({curTag, fetchIdx});
  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == (FPW+1)'(FIFO_DEPTH));
  assign newestPtr = wrPtr - FPW'(1);
  assign busyOut   = !fifoEmpty || (state != IDLE);

  // The cache holds its request as a level, so tags already in flight, already
  // queued last, or just answered are treated as repeats of the same miss.
  always_comb begin
    isDup  = ((state != IDLE) && (mem_reqTagIn == curTag))
          || (!fifoEmpty && (mem_reqTagIn == fifoMem[newestPtr]))
          || (prevRspVld && (mem_reqTagIn == prevRspTag));
    reqNew = mem_reqTagValidIn && !isDup;
    popEn  = ((state == IDLE) || (state == RESP)) && !fifoEmpty;
    pushEn = reqNew && (!fifoFull || popEn);
    dropEn = reqNew && fifoFull && !popEn;
  end

  // Request FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      overflowOut <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + FPW'(1);
      if (popEn)  rdPtr <= rdPtr + FPW'(1);
      if (pushEn && !popEn)      fifoCount <= fifoCount + (FPW+1)'(1);
      else if (!pushEn && popEn) fifoCount <= fifoCount - (FPW+1)'(1);
      if (dropEn) overflowOut <= 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge Clock) begin
    if (pushEn) fifoMem[wrPtr] <= mem_reqTagIn;
  end

  // Instruction RAM: loads and the read pipeline; NBA ordering gives read-first.
  always_ff @(posedge Clock) begin
    if (ld_wrEnIn) ram[ld_wrAddrIn] <= ld_wrDataIn;
    rdWord_p[0] <= ram[ramAddr];
    for (int i = 1; i < READ_LATENCY; i++) rdWord_p[i] <= rdWord_p[i-1];
  end

  // Read-valid tracking; reset drops any reads still in flight.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == FETCH);
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Word-index pipeline and line assembly as returned words arrive.
  always_ff @(posedge Clock) begin
    idx_p[0] <= fetchIdx;
    for (int i = 1; i < READ_LATENCY; i++) idx_p[i] <= idx_p[i-1];
    if (vld_p[READ_LATENCY-1])
      lineReg[WORD_WIDTH*idx_p[READ_LATENCY-1] +: WORD_WIDTH] <= rdWord_p[READ_LATENCY-1];
  end

  // Fetch sequencer with registered response outputs.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      state                  <= IDLE;
      fetchIdx               <= '0;
      curTag                 <= '0;
      lineDone               <= 1'b0;
      prevRspVld             <= 1'b0;
      prevRspTag             <= '0;
      mem_rspInsLineValidOut <= 1'b0;
      mem_rspTagOut          <= '0;
      mem_rspInsLineOut      <= '0;
    end else begin
      mem_rspInsLineValidOut <= 1'b0;
      prevRspVld             <= (state == RESP);
      prevRspTag             <= curTag;
      if (vld_p[READ_LATENCY-1] && (idx_p[READ_LATENCY-1] == 2'd3)) lineDone <= 1'b1;
      unique case (state)
        IDLE: begin
          if (popEn) begin
            state    <= FETCH;
            curTag   <= fifoMem[rdPtr];
            fetchIdx <= '0;
          end
        end
        FETCH: begin
          fetchIdx <= fetchIdx + 2'd1;
          if (fetchIdx == 2'd3) state <= WAIT;
        end
        WAIT: begin
          if (lineDone) begin
            state                  <= RESP;
            lineDone               <= 1'b0;
            mem_rspInsLineValidOut <= 1'b1;
            mem_rspTagOut          <= curTag;
            mem_rspInsLineOut      <= lineReg;
          end
        end
        RESP: begin
          if (popEn) begin
            state    <= FETCH;
            curTag   <= fifoMem[rdPtr];
            fetchIdx <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Testbench for ifu_mem_responder: directed table vectors, multi-cycle corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_ifu_mem_responder;
  localparam int TW = 28;
  localparam int LW = 128;
  localparam int WW = 32;
  localparam int MD = 1024;
  localparam int AW = 10;

  logic          Clock = 1'b0;
  logic          Rst = 1'b0;
  logic [TW-1:0] reqTag = '0;
  logic          reqValid = 1'b0;
  logic [TW-1:0] rspTag;
  logic [LW-1:0] rspLine;
  logic          rspValid;
  logic          ldEn = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [WW-1:0] ldData = '0;
  logic          busy, ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  ifu_mem_responder dut (
    .Clock(Clock), .Rst(Rst),
    .mem_reqTagIn(reqTag), .mem_reqTagValidIn(reqValid),
    .mem_rspTagOut(rspTag), .mem_rspInsLineOut(rspLine), .mem_rspInsLineValidOut(rspValid),
    .ld_wrEnIn(ldEn), .ld_wrAddrIn(ldAddr), .ld_wrDataIn(ldData),
    .busyOut(busy), .overflowOut(ovf)
  );

  // Reference model: pending-tag queue plus the edge at which the current
  // request was popped. Words are read on edges s+1..s+4, the pulse follows
  // edge s+7 and the next pop may happen at edge s+8.
  logic [WW-1:0] memM [MD];
  logic [TW-1:0] q[$];
  bit            curAct = 0;
  int            curS = 0;
  logic [TW-1:0] curTagM = '0;
  logic [LW-1:0] curLineM = '0;
  bit            lastVld = 0;
  int            lastEdge = 0;
  logic [TW-1:0] lastTag = '0;
  logic          expValid = 1'b0;
  logic [TW-1:0] expTag = '0;
  logic [LW-1:0] expLine = '0;
  logic          expBusy = 1'b0;
  logic          expOvf = 1'b0;
  int            n = 0;

  always @(posedge Clock) begin
    bit dup, popNow;
    int k;
    n++;
    if (!Rst) begin
      q.delete();
      curAct = 0; lastVld = 0;
      expValid = 1'b0; expTag = '0; expLine = '0; expOvf = 1'b0;
    end else begin
      dup = 0;
      if (curAct && n > curS && n <= curS + 8 && reqTag == curTagM) dup = 1;
      if (q.size() > 0 && q[$] == reqTag) dup = 1;
      if (lastVld && n == lastEdge + 1 && reqTag == lastTag) dup = 1;
      popNow = (q.size() > 0) && (!curAct || n >= curS + 8);
      expValid = 1'b0;
      if (curAct && n >= curS + 1 && n <= curS + 4) begin
        k = n - curS - 1;
        curLineM[32*k +: 32] = memM[((curTagM << 2) + k) % MD];
      end
      if (curAct && n == curS + 7) begin
        expValid = 1'b1; expTag = curTagM; expLine = curLineM;
      end
      if (curAct && n == curS + 8) begin
        lastVld = 1; lastTag = curTagM; lastEdge = n; curAct = 0;
      end
      if (popNow) begin
        curTagM = q.pop_front(); curS = n; curAct = 1;
      end
      if (reqValid && !dup) begin
        if (q.size() < 4) q.push_back(reqTag);
        else expOvf = 1'b1;
      end
    end
    if (ldEn) memM[ldAddr] = ldData;
    expBusy = (q.size() > 0) || curAct;
  end

  task automatic cmp(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h, want %h (edge %0d)", nm, act, exp, n);
      miscompares++;
    end
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    cmp(nm, act, exp);
  endtask

  task automatic chkInt(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      miscompares++;
    end
  endtask

  // One clock: sample #1 after the edge and compare every output to the model.
  task automatic step();
    @(posedge Clock);
    #1;
    vectors++;
    cmp("valid", LW'(rspValid), LW'(expValid));
    cmp("tag", LW'(rspTag), LW'(expTag));
    cmp("line", rspLine, expLine);
    cmp("busy", LW'(busy), LW'(expBusy));
    cmp("overflow", LW'(ovf), LW'(expOvf));
  endtask

  task automatic loadWord(input int a, input logic [WW-1:0] d);
    ldEn = 1'b1; ldAddr = AW'(a); ldData = d;
    step();
    ldEn = 1'b0;
  endtask

  // Drives one tag for 'hold' edges over 'total' edges; optional load write at edge wrAt.
  task automatic runReq(input logic [TW-1:0] tag, input int hold, input int total,
                        input int wrAt, input int wa, input logic [WW-1:0] wd,
                        output int pulses, output int lat,
                        output logic [LW-1:0] line, output logic [TW-1:0] rtag);
    pulses = 0; lat = -1; line = '0; rtag = '0;
    for (int e = 0; e < total; e++) begin
      reqValid = (e < hold); reqTag = tag;
      ldEn = (e == wrAt); ldAddr = AW'(wa); ldData = wd;
      step();
      if (rspValid === 1'b1) begin
        pulses++;
        if (lat < 0) begin lat = e; line = rspLine; rtag = rspTag; end
      end
    end
    reqValid = 1'b0; ldEn = 1'b0;
  endtask

  typedef struct {
    logic [TW-1:0] tag;
    int            base;
    logic [LW-1:0] line;
  } vecT;

  initial begin
    vecT           tbl [4];
    int            pulses, lat, pe [8], np;
    logic [LW-1:0] line;
    logic [TW-1:0] rtag, pt [8];

    tbl[0] = '{28'h0000100, 'h400, 128'h44444444_33333333_22222222_11111111};
    tbl[1] = '{28'h00001FF, 'h3FC, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000};
    tbl[2] = '{28'hABCDE05, 'h014, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0};
    tbl[3] = '{28'h0000042, 'h108, 128'hFFFFFFFF_00000000_80000001_7FFFFFFE};

    // Reset held low two cycles: everything idle and zero.
    step(); step();
    chk("rst_valid", LW'(rspValid), '0);
    chk("rst_tag", LW'(rspTag), '0);
    chk("rst_line", rspLine, '0);
    chk("rst_busy", LW'(busy), '0);
    chk("rst_ovf", LW'(ovf), '0);

    // Fill the whole RAM (writes work during reset).
    for (int i = 0; i < MD; i++) loadWord(i, $urandom);
    Rst = 1'b1;
    step();

    // Table vectors: load a line, hold the tag ten edges, expect one pulse 8 cycles later.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) loadWord(tbl[i].base + k, tbl[i].line[32*k +: 32]);
      runReq(tbl[i].tag, 10, 25, -1, 0, '0, pulses, lat, line, rtag);
      chkInt($sformatf("tbl%0d_pulses", i), pulses, 1);
      chkInt($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_tag", i), LW'(rtag), LW'(tbl[i].tag));
      chk($sformatf("tbl%0d_line", i), line, tbl[i].line);
    end
    chk("hold_after_pulse_tag", LW'(rspTag), LW'(tbl[3].tag));

    // Three tags on successive cycles: in-order pulses 8 cycles apart.
    np = 0;
    for (int e = 0; e < 36; e++) begin
      reqValid = (e < 3); reqTag = TW'(e + 1);
      step();
      if (rspValid === 1'b1 && np < 8) begin pe[np] = e; pt[np] = rspTag; np++; end
    end
    reqValid = 1'b0;
    chkInt("b2b_count", np, 3);
    for (int i = 0; i < 3; i++) begin
      chkInt($sformatf("b2b_edge%0d", i), pe[i], 8 + 8*i);
      chk($sformatf("b2b_tag%0d", i), LW'(pt[i]), LW'(i + 1));
    end

    // Six distinct tags while busy: one in flight, four queued, sixth dropped.
    np = 0;
    for (int e = 0; e < 50; e++) begin
      reqValid = (e < 6); reqTag = TW'(28'h10 + e);
      step();
      if (e == 4) chk("ovf_before_drop", LW'(ovf), '0);
      if (e == 5) chk("ovf_after_drop", LW'(ovf), 1);
      if (rspValid === 1'b1 && np < 8) begin pt[np] = rspTag; np++; end
    end
    reqValid = 1'b0;
    chkInt("ovf_pulses", np, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("ovf_tag%0d", i), LW'(pt[i]), LW'(28'h10 + i));
    chk("ovf_sticky", LW'(ovf), 1);
    Rst = 1'b0; step(); step();
    chk("ovf_cleared", LW'(ovf), '0);
    chk("rst2_tag", LW'(rspTag), '0);
    chk("rst2_line", rspLine, '0);
    Rst = 1'b1; step();

    // Reset during the fetch of tag 5: no response ever, next request normal.
    reqValid = 1'b1; reqTag = 28'h5; step();
    reqValid = 1'b0; step(); step();
    chk("fetch_busy", LW'(busy), 1);
    Rst = 1'b0; step();
    Rst = 1'b1;
    chk("midrst_busy", LW'(busy), '0);
    np = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (rspValid === 1'b1) np++;
    end
    chkInt("midrst_no_pulse", np, 0);
    runReq(28'h6, 1, 20, -1, 0, '0, pulses, lat, line, rtag);
    chkInt("after_rst_latency", lat, 8);
    chk("after_rst_tag", LW'(rtag), 28'h6);

    // Load write to word 0x14 on the edge it is read: old data, then new on refetch.
    loadWord('h14, 32'hA0A0A0A0);
    loadWord('h15, 32'hA1A1A1A1);
    loadWord('h16, 32'hA2A2A2A2);
    loadWord('h17, 32'hA3A3A3A3);
    runReq(28'h5, 1, 20, 2, 'h14, 32'hB0B0B0B0, pulses, lat, line, rtag);
    chk("rf_old_line", line, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    runReq(28'h5, 1, 20, -1, 0, '0, pulses, lat, line, rtag);
    chk("rf_new_word0", LW'(line[31:0]), 32'hB0B0B0B0);

    // Randomized traffic: small tag set for dedupe hits, loads, occasional reset.
    for (int i = 0; i < 800; i++) begin
      reqValid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) reqTag = TW'($urandom_range(0, 7));
      ldEn = ($urandom_range(0, 3) == 0);
      ldAddr = AW'($urandom_range(0, 31));
      ldData = $urandom;
      Rst = ($urandom_range(0, 149) != 0);
      step();
    end
    Rst = 1'b1; reqValid = 1'b0; ldEn = 1'b0;
    for (int i = 0; i < 60; i++) step();
    chk("drain_busy", LW'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
